// File: rtl/dataflow_collect.sv
// Collects a lane x 16 result array in one capture and either drains it lane by lane
// (gather) or sums it across lanes with saturation into a single 16-word beat (reduce).
module dataflow_collect #(
  parameter int IL   = 8,
  parameter int FL   = 12,
  parameter int lane = 128
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             mode,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic signed [IL+FL-1:0]          in [lane][16],
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic signed [IL+FL-1:0]          out [16],
  output logic        [$clog2(lane)-1:0]   out_lane,
  output logic                             out_last
);

  localparam int W  = IL + FL;
  localparam int LW = $clog2(lane);
  localparam int AW = W + LW;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GATHER = 2'd1;
  localparam logic [1:0] REDUCE = 2'd2;
  localparam logic [1:0] EMIT   = 2'd3;

  localparam logic [LW-1:0]        LAST = LW'(lane - 1);
  localparam logic signed [AW-1:0] SMAX = AW'((64'sd1 <<< (W - 1)) - 64'sd1);
  localparam logic signed [AW-1:0] SMIN = -SMAX - AW'(1);

  logic [1:0]             state;
  logic [LW-1:0]          cnt;
  logic [LW-1:0]          nxt;
  logic signed [W-1:0]    data_buf [lane][16];
  logic signed [AW-1:0]   acc [16];
  logic signed [AW-1:0]   sum [16];

  function automatic logic signed [W-1:0] sat(input logic signed [AW-1:0] a);
    if (a > SMAX)      return SMAX[W-1:0];
    else if (a < SMIN) return SMIN[W-1:0];
    else               return a[W-1:0];
  endfunction

  assign in_ready = (state == IDLE);
  assign nxt      = cnt + LW'(1);

  // Running sum including the lane currently addressed; the final lane's
  // contribution goes straight to the saturated output register.
  always_comb begin
    for (int k = 0; k < 16; k++) begin
      sum[k] = acc[k] + AW'(data_buf[cnt][k]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_lane  <= '0;
      out_last  <= 1'b0;
      for (int k = 0; k < 16; k++) begin
        acc[k] <= '0;
        out[k] <= '0;
      end
      for (int j = 0; j < lane; j++) begin
        for (int k = 0; k < 16; k++) begin
          data_buf[j][k] <= '0;
        end
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_buf <= in;
            cnt      <= '0;
            for (int k = 0; k < 16; k++) acc[k] <= '0;
            if (mode) begin
              state     <= GATHER;
              out       <= in[0];
              out_lane  <= '0;
              out_last  <= (LAST == '0);
              out_valid <= 1'b1;
            end else begin
              state <= REDUCE;
            end
          end
        end
        GATHER: begin
          if (out_ready) begin
            if (cnt == LAST) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              cnt      <= nxt;
              out      <= data_buf[nxt];
              out_lane <= nxt;
              out_last <= (nxt == LAST);
            end
          end
        end
        REDUCE: begin
          for (int k = 0; k < 16; k++) acc[k] <= sum[k];
          if (cnt == LAST) begin
            cnt       <= '0;
            state     <= EMIT;
            out_valid <= 1'b1;
            out_lane  <= '0;
            out_last  <= 1'b1;
            for (int k = 0; k < 16; k++) out[k] <= sat(sum[k]);
          end else begin
            cnt <= nxt;
          end
        end
        default: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/dataflow_collect.md
DATAFLOW_COLLECT -- requirements
Module: dataflow_collect

Interface
REQ-001 Parameter IL, default 8, integer bits of each signed fixed-point word.
REQ-002 Parameter FL, default 12, fractional bits of each signed fixed-point word; word width W = IL+FL.
REQ-003 Parameter lane, default 128, number of lanes, each lane 16 words wide; LW = clog2(lane).
REQ-004 clk  input  1  sole clock; all state updates on posedge.
REQ-005 reset  input  1  asynchronous, active-low; 0 = reset asserted.
REQ-006 mode  input  1  sampled only at capture; 0 = reduce (sum across lanes), 1 = gather (lane-by-lane drain).
REQ-007 in_valid  input  1  producer presents a full lane x 16 array.
REQ-008 in_ready  output  1  block can capture; high only in IDLE.
REQ-009 in  input  signed [W-1:0] x [lane][16]  result array from the lane datapath.
REQ-010 out_valid  output  1  out, out_lane and out_last are valid.
REQ-011 out_ready  input  1  consumer accepts the current beat.
REQ-012 out  output  signed [W-1:0] x [16]  one 16-word vector per beat.
REQ-013 out_lane  output  LW  lane index of the current beat; 0 in reduce mode.
REQ-014 out_last  output  1  final beat of the current capture.

Function
REQ-015 FSM states SHALL be IDLE, GATHER, REDUCE and EMIT; all outputs SHALL be driven from registers or state only, with no combinational path from in, in_valid or out_ready.
REQ-016 IDLE: in_ready=1, out_valid=0; on in_valid=1 the block SHALL register in into buf, latch mode, clear cnt and acc, then go to GATHER (mode=1) or REDUCE (mode=0).
REQ-017 GATHER: out_valid=1, out=buf[cnt], out_lane=cnt, out_last=(cnt==lane-1).
REQ-018 GATHER handshake: a beat transfers only when out_valid and out_ready are both 1; on transfer, cnt increments, or the FSM returns to IDLE if cnt==lane-1.
REQ-019 While out_ready=0, out, out_lane and out_last SHALL hold stable; no beat is dropped or duplicated.
REQ-020 REDUCE: each cycle acc[k] += buf[cnt][k] for k=0..15, cnt increments, out_valid=0; after the cnt==lane-1 add, the FSM goes to EMIT, so REDUCE lasts exactly lane cycles.
REQ-021 acc words SHALL be W+LW bits signed, so internal overflow is impossible.
REQ-022 EMIT: out_valid=1, out[k]=sat(acc[k]), out_lane=0, out_last=1; on transfer the FSM returns to IDLE.
REQ-023 sat() SHALL clamp to [-2^(W-1), 2^(W-1)-1] and otherwise pass the low W bits unchanged.
REQ-024 After the final transfer, in_ready SHALL rise on the next cycle (one bubble); capture is not permitted in the same cycle as the final transfer.
REQ-025 in_valid and mode changes outside IDLE SHALL be ignored, and buf SHALL be unchanged.
REQ-026 Reduce latency: capture edge to out_valid=1 is lane+1 cycles; gather latency is 1 cycle.

Reset
REQ-027 When reset=0, asynchronously: state=IDLE, cnt=0, acc=0, buf=0, out=0, out_lane=0, out_last=0, out_valid=0, and in_ready=1 as soon as reset deasserts.
REQ-028 Reset asserted mid-GATHER, mid-REDUCE or in EMIT SHALL abandon the capture with no further beats.

Verification (lane=4 plus default lane=128; raw hex values, W=20)
REQ-029 Gather: in[j][k]=j*16+k, mode=1, out_ready=1 -> 4 consecutive beats with out_lane 0..3, out[k]=j*16+k, out_last only on beat 3, in_ready=1 the cycle after.
REQ-030 Reduce: all in=0x01000 (1.0), mode=0 -> out_valid rises 5 cycles after capture, out[k]=0x04000, out_lane=0, out_last=1.
REQ-031 Saturation: all in=0x7FFFF with mode=0 -> out=0x7FFFF; all in=0x80000 -> out=0x80000; mixed +0x7FFFF/-0x80000 pairs -> exact sum 0xFFFFE.
REQ-032 Backpressure: gather with out_ready pattern 1,0,0,1,0,1,1 -> outputs stable during stalls, exactly 4 transfers in order.
REQ-033 Busy input: in_valid pulsed with new data and mode flipped during GATHER/REDUCE -> no capture, in_ready=0, original data emitted.
REQ-034 Reset: reset=0 at gather beat 2 -> out_valid=0 and out=0 immediately, no further beats, in_ready=1 after release, and the next capture behaves per REQ-029.
